maxpool2d_2x2_stride_2x2: RTL and testbench
===========================================

// Module: maxpool2d_2x2_stride_2x2
// PURPOSE
//  Streaming 2x2 max-pool, stride 2, directly downstream of the 3x3 convolution stage.
//  Consumes the raster-order output of the convolution, one IEEE-754 single per Valid_In.
//  Emits one pooled value per 2x2 window, also in raster order, to the next layer.
//  Holds one half-row of horizontal pair maxima in a line buffer; no backpressure.
// PARAMETERS
//  IMG_WIDHT   30  input pixels per row; must be >= 2
//  IMG_HEIGHT  30  input rows per frame; must be >= 2
//  OUT_W = IMG_WIDHT/2 and OUT_H = IMG_HEIGHT/2 are derived (floor).
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-low
//  Data_In    in   32  IEEE-754 single, input pixel
//  Valid_In   in   1   Data_In valid this cycle
//  Data_Out   out  32  IEEE-754 single, pooled value
//  Valid_Out  out  1   Data_Out valid; 1-cycle pulse per window
// BEHAVIOUR
//  - Reset (rst=0, async): col=0, row=0, pair register cleared, Data_Out=0, Valid_Out=0.
//    Line buffer contents need not be cleared; they are always written before being read.
//  - Counters advance only on Valid_In=1. Gaps are allowed.
//    col runs 0..IMG_WIDHT-1; on wrap, row increments.
//    row runs 0..IMG_HEIGHT-1; on wrap (end of frame), row=0 and the next frame starts seamlessly.
//  - Even col (< 2*OUT_W): latch Data_In into the pair register.
//  - Odd col: pm = fmax(pair register, Data_In).
//    Even row: write pm to line_buf[col>>1].
//    Odd row:  Data_Out <= fmax(line_buf[col>>1], pm); Valid_Out <= 1 on the next edge.
//  - Latency: Valid_Out asserts exactly 1 cycle after the Valid_In that carries the
//    odd-row, odd-column pixel. Valid_Out=0 in every other cycle.
//    Data_Out holds its last value while Valid_Out=0.
//  - Odd IMG_WIDHT: the last column of each row is discarded (counted, never stored).
//    Odd IMG_HEIGHT: the last row is discarded. No output is generated for either.
//  - fmax(a,b), compare-only, no FP arithmetic:
//    signs differ -> operand with sign=0.
//    both sign=0  -> larger magnitude bits.
//    both sign=1  -> smaller magnitude bits.
//    Tie (incl. +0 vs -0) -> a (the earlier operand).
//    NaN/Inf are ordered by bit pattern per the rules above; no special handling.
//  - Per frame: exactly OUT_W*OUT_H Valid_Out pulses.
//  - Reset mid-frame: partial windows are dropped. The first Valid_In after release is row 0, col 0.
//  - Single-port line buffer suffices: each index is written (even row) and read (odd row)
//    in different rows; read and write never coincide.
// CONFIGURATION
//  RELU_POOL_EN defined:
//    - Final Data_Out is rectified: any result with sign=1 is replaced by 32'h0000_0000.
//    - Fuses the activation; latency unchanged.
//  RELU_POOL_EN undefined:
//    - Data_Out is the raw max, negatives pass through.
// TESTING
//  1. IMG 4x4, pixels 1.0..16.0 (float) raster, Valid_In every cycle.
//     -> 4 pulses: 6.0, 8.0, 14.0, 16.0 (0x40C00000, 0x41000000, 0x41600000, 0x41800000).
//  2. Window {-1.0, -3.0, -2.0, -0.5} (0xBF800000 ...) without RELU_POOL_EN -> 0xBF000000 (-0.5).
//     With RELU_POOL_EN -> 0x00000000.
//  3. Sign mix: window {0xBF800000, 0x00000000, 0x80000000, 0x3F800000} -> 0x3F800000.
//     Window {+0, -0, -0, +0} -> 0x00000000.
//  4. IMG 5x5, 25 pixels with random Valid_In gaps.
//     -> exactly 4 pulses; column 4 and row 4 never influence outputs.
//     Each pulse arrives 1 cycle after its last pixel.
//  5. Default 30x30, two back-to-back frames -> 225 pulses per frame; frame 2 matches the golden model.
//  6. Assert rst after 37 pixels of a 4x4 frame, then send a fresh frame 1.0..16.0.
//     -> Data_Out/Valid_Out =0 during reset; outputs afterwards identical to scenario 1.

Source files
------------

// File: rtl/maxpool2d_2x2_stride_2x2_if.sv
// maxpool2d_2x2_stride_2x2_if: pixel stream in / pooled stream out for the 2x2 max-pool
// Signals:
//   Data_In   [31:0] IEEE-754 single, input pixel
//   Valid_In         Data_In valid this cycle
//   Data_Out  [31:0] IEEE-754 single, pooled value
//   Valid_Out        Data_Out valid, 1-cycle pulse per window
// Modports: master = pixel producer, slave = pooling block
interface maxpool2d_2x2_stride_2x2_if;
   logic [31:0] Data_In;
   logic        Valid_In;
   logic [31:0] Data_Out;
   logic        Valid_Out;
   modport master (output Data_In, Valid_In, input Data_Out, Valid_Out);
   modport slave (input Data_In, Valid_In, output Data_Out, Valid_Out);
endinterface

// File: rtl/maxpool2d_2x2_stride_2x2.sv
// maxpool2d_2x2_stride_2x2: streaming 2x2 stride-2 max-pool over raster-order IEEE-754 singles
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-low
//   bus  slave side of maxpool2d_2x2_stride_2x2_if (Data_In/Valid_In in, Data_Out/Valid_Out out)
// Parameters: IMG_WIDHT, IMG_HEIGHT (>= 2); a trailing odd column/row is counted and dropped.
// Build option: define RELU_POOL_EN to rectify the pooled result (sign=1 -> 32'h0).
module maxpool2d_2x2_stride_2x2 #(
   parameter int IMG_WIDHT  = 30,
   parameter int IMG_HEIGHT = 30
) (
   input logic clk,
   input logic rst,
   maxpool2d_2x2_stride_2x2_if.slave bus
);
   localparam int OUT_W = IMG_WIDHT / 2;
   localparam int OUT_H = IMG_HEIGHT / 2;
   // one spare bit so that 2*OUT_W / 2*OUT_H are representable for the window bounds
   localparam int CW = $clog2(IMG_WIDHT) + 1;
   localparam int RW = $clog2(IMG_HEIGHT) + 1;
   localparam int LW = OUT_W > 1 ? $clog2(OUT_W) : 1;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [31:0]   pair, pm, best, res;
   logic [31:0]   line_buf [OUT_W];
   logic [LW-1:0] idx;
   logic          last_col, last_row, latch, wr, fire;

   // ordering by sign then magnitude bits; equal values and +0/-0 keep the earlier operand a
   function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
      if (a[30:0] == '0 && b[30:0] == '0) return a;
      if (a[31] != b[31]) return a[31] ? b : a;
      if (!a[31]) return b[30:0] > a[30:0] ? b : a;
      return b[30:0] < a[30:0] ? b : a;
   endfunction

   always_comb begin
      last_col = col == CW'(IMG_WIDHT - 1);
      last_row = row == RW'(IMG_HEIGHT - 1);
      idx      = LW'(col >> 1);
      pm       = fmax(pair, bus.Data_In);
      latch    = bus.Valid_In & ~col[0] & (col < CW'(2 * OUT_W));
      wr       = bus.Valid_In & col[0] & ~row[0] & (row < RW'(2 * OUT_H));
      fire     = bus.Valid_In & col[0] & row[0];
      best     = fmax(line_buf[idx], pm);
`ifdef RELU_POOL_EN
      res      = best[31] ? 32'h0 : best;
`else
      res      = best;
`endif
   end

   // line buffer is always written in an even row before the odd row reads it, so no reset
   always_ff @(posedge clk)
      if (wr) line_buf[idx] <= pm;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col           <= '0;
         row           <= '0;
         pair          <= '0;
         bus.Data_Out  <= '0;
         bus.Valid_Out <= 1'b0;
      end else begin
         bus.Valid_Out <= fire;
         if (fire) bus.Data_Out <= res;
         if (latch) pair <= bus.Data_In;
         if (bus.Valid_In) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) row <= last_row ? '0 : row + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_maxpool2d_2x2_stride_2x2.sv
// tb_maxpool2d_2x2_stride_2x2: directed checks of the 2x2 max-pool on 4x4, 5x5 and 30x30 instances
module tb_maxpool2d_2x2_stride_2x2;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   maxpool2d_2x2_stride_2x2_if i4 ();
   maxpool2d_2x2_stride_2x2_if i5 ();
   maxpool2d_2x2_stride_2x2_if i30 ();

   maxpool2d_2x2_stride_2x2 #(.IMG_WIDHT(4), .IMG_HEIGHT(4)) u4 (.clk(clk), .rst(rst), .bus(i4.slave));
   maxpool2d_2x2_stride_2x2 #(.IMG_WIDHT(5), .IMG_HEIGHT(5)) u5 (.clk(clk), .rst(rst), .bus(i5.slave));
   maxpool2d_2x2_stride_2x2 u30 (.clk(clk), .rst(rst), .bus(i30.slave));

   logic [31:0] got4[$], got5[$], got30[$], exp_q[$];
   int          at5[$], exp_at[$];
   logic [31:0] f [30][30];

   logic [31:0] ramp [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                              32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                              32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
   logic [31:0] s2 [16] = '{32'hBF800000, 32'hC0400000, 32'hBF800000, 32'h00000000,
                            32'hC0000000, 32'hBF000000, 32'h80000000, 32'h3F800000,
                            32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
                            32'h80000000, 32'h00000000, 32'h3F800000, 32'hFF800000};

   always @(negedge clk) begin
      if (i4.Valid_Out) got4.push_back(i4.Data_Out);
      if (i5.Valid_Out) begin
         got5.push_back(i5.Data_Out);
         at5.push_back(cyc);
      end
      if (i30.Valid_Out) got30.push_back(i30.Data_Out);
   end

   // reference ordering: map each float to an unsigned key that sorts like the float
   function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ka, kb;
      if (a[30:0] == 31'h0 && b[30:0] == 31'h0) return a;
      ka = a[31] ? ~a : {1'b1, a[30:0]};
      kb = b[31] ? ~b : {1'b1, b[30:0]};
      return kb > ka ? b : a;
   endfunction

   function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef RELU_POOL_EN
      return x[31] ? 32'h0 : x;
`else
      return x;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input int u, input logic [31:0] d, output int e);
      if (u == 4) begin i4.Data_In = d; i4.Valid_In = 1'b1; end
      else if (u == 5) begin i5.Data_In = d; i5.Valid_In = 1'b1; end
      else begin i30.Data_In = d; i30.Valid_In = 1'b1; end
      @(posedge clk);
      #1;
      e = cyc;
      i4.Valid_In = 1'b0;
      i5.Valid_In = 1'b0;
      i30.Valid_In = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string tag, input int u);
      logic [31:0] g[$];
      if (u == 4) g = got4;
      else if (u == 5) g = got5;
      else g = got30;
      check($sformatf("%s_count", tag), g.size(), exp_q.size());
      foreach (exp_q[i])
         if (i < g.size()) check($sformatf("%s_%0d", tag, i), g[i], exp_q[i]);
      if (u == 4) got4.delete();
      else if (u == 5) got5.delete();
      else got30.delete();
      exp_q.delete();
   endtask

   task automatic ramp_frame();
      int e;
      for (int i = 0; i < 16; i++) push(4, ramp[i], e);
   endtask

   initial begin
      int e;
      i4.Data_In = '0;  i4.Valid_In = 1'b0;
      i5.Data_In = '0;  i5.Valid_In = 1'b0;
      i30.Data_In = '0; i30.Valid_In = 1'b0;
      idle(3);
      check("rst_valid4", i4.Valid_Out, 0);
      check("rst_data4", i4.Data_Out, 0);
      check("rst_valid30", i30.Valid_Out, 0);
      check("rst_data30", i30.Data_Out, 0);
      rst = 1'b1;
      idle(1);

      ramp_frame();
      idle(3);
      check("hold_last", i4.Data_Out, 32'h41800000);
      exp_q = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
      drain("s1", 4);

      for (int i = 0; i < 16; i++) push(4, s2[i], e);
      idle(3);
      exp_q = '{relu(32'hBF000000), 32'h3F800000, 32'h00000000, 32'h7FC00000};
      drain("s2", 4);

      for (int fr = 0; fr < 2; fr++)
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
               push(5, (r < 4 && c < 4) ? ramp[r * 4 + c] : 32'h7F7FFFFF, e);
               if (r < 4 && c < 4 && r[0] && c[0]) exp_at.push_back(e);
               idle($urandom_range(0, 2));
            end
      idle(3);
      check("s4_lat_count", at5.size(), exp_at.size());
      foreach (exp_at[i])
         if (i < at5.size()) check($sformatf("s4_lat_%0d", i), at5[i], exp_at[i]);
      for (int fr = 0; fr < 2; fr++) begin
         exp_q.push_back(32'h40C00000);
         exp_q.push_back(32'h41000000);
         exp_q.push_back(32'h41600000);
         exp_q.push_back(32'h41800000);
      end
      drain("s4", 5);

      for (int fr = 0; fr < 2; fr++) begin
         for (int r = 0; r < 30; r++)
            for (int c = 0; c < 30; c++) f[r][c] = $urandom;
         for (int wr = 0; wr < 15; wr++)
            for (int wc = 0; wc < 15; wc++)
               exp_q.push_back(relu(ref_max(ref_max(f[2*wr][2*wc], f[2*wr][2*wc+1]),
                                            ref_max(f[2*wr+1][2*wc], f[2*wr+1][2*wc+1]))));
         for (int r = 0; r < 30; r++)
            for (int c = 0; c < 30; c++) push(30, f[r][c], e);
      end
      idle(3);
      drain("s5", 30);

      for (int i = 0; i < 37; i++) push(4, ramp[i % 16], e);
      idle(1);
      for (int fr = 0; fr < 2; fr++) begin
         exp_q.push_back(32'h40C00000);
         exp_q.push_back(32'h41000000);
         exp_q.push_back(32'h41600000);
         exp_q.push_back(32'h41800000);
      end
      drain("s6_pre", 4);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("s6_rst_valid_%0d", i), i4.Valid_Out, 0);
         check($sformatf("s6_rst_data_%0d", i), i4.Data_Out, 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(1);
      ramp_frame();
      idle(3);
      exp_q = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
      drain("s6", 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
